line_echo_ctrl: RTL

LINE_ECHO_CTRL -- requirements
Module: line_echo_ctrl

---
 rtl/line_echo_pkg.sv | 14 +
 rtl/line_echo_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/line_echo_pkg.sv
// Shared definitions for the line echo datapath: controller state encoding
// and the default end-of-line byte.
package line_echo_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,  // discard FIFO residue left over from before reset
    ST_FILL  = 2'd1,  // collect received bytes until EOL
    ST_DRAIN = 2'd2,  // echo buffered line one byte at a time
    ST_GAP   = 2'd3   // one-cycle spacer after each transmit request
  } state_e;

  localparam logic [7:0] EOL_DEFAULT = 8'h0D;

endpackage

// File: rtl/line_echo_ctrl.sv
// Line echo controller: buffers received bytes into an external FWFT FIFO
// until an EOL byte arrives, then replays the whole line to the transmitter.
// Bytes arriving while not filling (or with the FIFO full) are dropped and
// flagged on a sticky overflow bit.
module line_echo_ctrl
  import line_echo_pkg::*;
#(
  parameter int             BW     = 8,
  parameter int             LGFLEN = 4,
  parameter logic [BW-1:0]  EOL    = BW'(EOL_DEFAULT)
)(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx_stb,
  input  logic [BW-1:0]     i_rx_data,
  output logic              o_tx_stb,
  output logic [BW-1:0]     o_tx_data,
  input  logic              i_tx_busy,
  output logic              o_fifo_wr,
  output logic [BW-1:0]     o_fifo_data,
  input  logic              i_fifo_full,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd,
  input  logic [BW-1:0]     i_fifo_data,
  output logic [LGFLEN:0]   o_line_len,
  output logic              o_busy,
  output logic              o_overflow,
  input  logic              i_ovf_clr
);

  localparam logic [LGFLEN:0] LEN_MAX = {1'b1, {LGFLEN{1'b0}}};

  state_e state, state_nxt;
  logic   rx_eol;
  logic   tx_go;       // pop head byte and launch it to the transmitter
  logic   drain_done;  // line fully echoed, back to collecting
  logic   rx_drop;

  assign rx_eol      = i_rx_stb && (i_rx_data == EOL);
  assign rx_drop     = i_rx_stb && !o_fifo_wr;
  assign o_fifo_data = i_rx_data;
  assign o_busy      = (state != ST_FILL);

  // Next-state and FIFO handshake decode; write only in FILL, read only in
  // FLUSH/DRAIN, so the two strobes are mutually exclusive by construction.
  always_comb begin
    state_nxt  = state;
    o_fifo_rd  = 1'b0;
    o_fifo_wr  = 1'b0;
    tx_go      = 1'b0;
    drain_done = 1'b0;
    case (state)
      ST_FLUSH: begin
        o_fifo_rd = !i_fifo_empty;
        if (i_fifo_empty) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        o_fifo_wr = i_rx_stb && !i_fifo_full;
        if (rx_eol) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_tx_busy) begin
          if (!i_fifo_empty && !o_tx_stb) begin
            o_fifo_rd = 1'b1;
            tx_go     = 1'b1;
            state_nxt = ST_GAP;
          end else if (i_fifo_empty) begin
            drain_done = 1'b1;
            state_nxt  = ST_FILL;
          end
        end
      end
      ST_GAP:  state_nxt = ST_DRAIN;
      default: state_nxt = ST_FLUSH;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_FLUSH;
    else            state <= state_nxt;
  end

  // Transmit request: one-cycle strobe, data held until the next launch.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_tx_stb  <= 1'b0;
      o_tx_data <= '0;
    end else begin
      o_tx_stb <= tx_go;
      if (tx_go) o_tx_data <= i_fifo_data;
    end
  end

  // Line length: counts accepted bytes, saturates, clears once drained.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                           o_line_len <= '0;
    else if (drain_done)                      o_line_len <= '0;
    else if (o_fifo_wr && o_line_len != LEN_MAX) o_line_len <= o_line_len + 1'b1;
  end

  // Sticky overflow; a drop in the same cycle beats the clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)     o_overflow <= 1'b0;
    else if (rx_drop)   o_overflow <= 1'b1;
    else if (i_ovf_clr) o_overflow <= 1'b0;
  end

endmodule
